blur_controller: RTL and testbench
==================================

BLUR_CONTROLLER -- requirements
Module: blur_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge active.
REQ-002 SHALL have ports: n_rst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: anchor_moving  in  1  level request to process the presented row.
REQ-004 SHALL have ports: anchor_x  in  32  row index of presented row within strip; 0 = first row.
REQ-005 SHALL have ports: anchor_y  in  32  strip/column-block position tag.
REQ-006 SHALL have ports: blur_in  in  20x8 (unpacked [20])  presented row, unsigned pixels, index 0..19.
REQ-007 SHALL have ports: blur_out  out  16x8 (unpacked [16])  blurred pixels, registered.
REQ-008 SHALL have ports: blur_final  out  1  one-cycle pulse, blur_out complete.

Function
REQ-009 SHALL keep a 5-row line buffer R0 (oldest) .. R4 (newest), 20 x 8-bit each.
REQ-010 SHALL accept a row in IDLE at a rising edge where anchor_moving=1 and (no row accepted since reset, or {anchor_x,anchor_y} differs from the last accepted pair).
REQ-011 SHALL, on accept, shift R0<=R1, R1<=R2, R2<=R3, R3<=R4, R4<=blur_in, and record {anchor_x,anchor_y}.
REQ-012 SHALL, on accept with anchor_x==0, load blur_in into all of R0..R4 (top-border replication).
REQ-013 SHALL use kernel K[r][c] = w[r]*w[c], w = {1,4,8,4,1}, r = buffer row 0..4, c = column offset 0..4; sum of weights 324.
REQ-014 SHALL compute blur_out[k], k=0..15, as floor( sum over r,c of K[r][c]*R[r][k+c] / 324 ); accumulator >= 17 bits unsigned (max 82620); result always 0..255.
REQ-015 SHALL use FSM IDLE -> COMPUTE -> DONE -> IDLE.
REQ-016 SHALL enter COMPUTE on the accept edge with column counter k=0.
REQ-017 SHALL, in COMPUTE, write one blur_out[k] per rising edge, k=0..15; after the edge writing k=15, go to DONE.
REQ-018 SHALL assert blur_final only in DONE (exactly one cycle), then return to IDLE; blur_final rises 16 edges after the accept edge.
REQ-019 SHALL hold all blur_out values stable from DONE until the next accept; unwritten entries keep prior values during COMPUTE.
REQ-020 SHALL ignore anchor_moving, anchor_x, anchor_y and blur_in while in COMPUTE or DONE; a new accept can occur at the first edge in IDLE.
REQ-021 SHALL NOT recompute when anchor_moving stays high with an unchanged {anchor_x,anchor_y}.

Reset
REQ-022 SHALL, while n_rst=0, force state IDLE, k=0, blur_final=0, all blur_out=0, all line buffer entries 0, and the accepted-anchor flag cleared.
REQ-023 SHALL abort any COMPUTE on reset; no blur_final pulse for the aborted row.

Verification
REQ-024 Uniform: after reset, anchor_x=0, all blur_in=200 -> blur_final after 16 edges; all blur_out=200.
REQ-025 Saturation: anchor_x=0, all 255 -> all blur_out=255; all 0 -> all 0.
REQ-026 Impulse: row x=0 all 0, then x=1 with blur_in[10]=255, others 0 -> blur_out[8]=6, [7]=[9]=3, [6]=[10]=0, all others 0.
REQ-027 Border sequence: random rows at x=0,1,2 with anchor_moving held high -> each blur_out equals REQ-014 using rows (A,A,A,A,A), (A,A,A,A,B), (A,A,A,B,C); exactly one blur_final pulse per row.
REQ-028 No retrigger: anchor held constant with anchor_moving=1 for 40 cycles after DONE -> no further blur_final; blur_out unchanged.
REQ-029 Reset mid-COMPUTE at k=7 -> blur_out all 0, blur_final stays 0, next accept with anchor_x=0 behaves per REQ-024.

Source files
------------

// File: rtl/blur_controller.sv
// 5x5 separable-weight blur over a 5-row line buffer; produces 16 output pixels
// one column per clock after each newly presented row.
module blur_controller (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        anchor_moving,
  input  logic [31:0] anchor_x,
  input  logic [31:0] anchor_y,
  input  logic [7:0]  blur_in [20],
  output logic [7:0]  blur_out [16],
  output logic        blur_final
);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  col;
  logic [7:0]  rows [5][20];
  logic [63:0] last_anchor;
  logic        anchor_valid;
  logic        accept;
  logic [16:0] acc;
  logic [4:0]  idx;
  logic [7:0]  pixel;

  function automatic logic [16:0] weight(input int i);
    case (i)
      0, 4:    weight = 17'd1;
      1, 3:    weight = 17'd4;
      default: weight = 17'd8;
    endcase
  endfunction

  // A row is taken only in IDLE and only if its anchor is new since the last accept.
  assign accept = (state == IDLE) && anchor_moving &&
                  (!anchor_valid || ({anchor_x, anchor_y} != last_anchor));

  always_comb begin
    acc = '0;
    idx = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        idx = {1'b0, col} + 5'(c);
        acc = acc + weight(r) * weight(c) * {9'd0, rows[r][idx]};
      end
    end
    pixel = 8'(acc / 17'd324);
  end

  always_comb begin
    state_next = state;
    blur_final = 1'b0;
    case (state)
      IDLE:    if (accept) state_next = COMPUTE;
      COMPUTE: if (col == 4'd15) state_next = DONE;
      DONE: begin
        blur_final = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      col          <= 4'd0;
      last_anchor  <= 64'd0;
      anchor_valid <= 1'b0;
      for (int k = 0; k < 16; k++) blur_out[k] <= 8'd0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 20; c++) rows[r][c] <= 8'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        col          <= 4'd0;
        last_anchor  <= {anchor_x, anchor_y};
        anchor_valid <= 1'b1;
        // First row of a strip is replicated upward to fill the window.
        for (int c = 0; c < 20; c++) begin
          if (anchor_x == 32'd0) begin
            for (int r = 0; r < 5; r++) rows[r][c] <= blur_in[c];
          end else begin
            for (int r = 0; r < 4; r++) rows[r][c] <= rows[r+1][c];
            rows[4][c] <= blur_in[c];
          end
        end
      end else if (state == COMPUTE) begin
        blur_out[col] <= pixel;
        col           <= col + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_blur_controller.sv
// Randomized self-checking bench for blur_controller against a behavioural
// line-buffer/convolution model.
module tb_blur_controller;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        anchor_moving = 1'b0;
  logic [31:0] anchor_x = 32'd0;
  logic [31:0] anchor_y = 32'd0;
  logic [7:0]  blur_in [20];
  logic [7:0]  blur_out [16];
  logic        blur_final;

  int checks = 0;
  int failures = 0;
  int model_rows [5][20];
  int w [5] = '{1, 4, 8, 4, 1};

  blur_controller dut (
    .clk(clk),
    .n_rst(n_rst),
    .anchor_moving(anchor_moving),
    .anchor_x(anchor_x),
    .anchor_y(anchor_y),
    .blur_in(blur_in),
    .blur_out(blur_out),
    .blur_final(blur_final)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 20; c++) model_rows[r][c] = 0;
  endtask

  task automatic model_accept(input logic [31:0] x, input logic [7:0] px [20]);
    if (x == 32'd0) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 20; c++) model_rows[r][c] = int'(px[c]);
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 20; c++) model_rows[r][c] = model_rows[r+1][c];
      for (int c = 0; c < 20; c++) model_rows[4][c] = int'(px[c]);
    end
  endtask

  function automatic int model_pixel(input int k);
    int sum = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) sum += w[r] * w[c] * model_rows[r][k+c];
    return sum / 324;
  endfunction

  task automatic fill_const(output logic [7:0] px [20], input logic [7:0] v);
    for (int c = 0; c < 20; c++) px[c] = v;
  endtask

  task automatic fill_rand(output logic [7:0] px [20]);
    for (int c = 0; c < 20; c++) px[c] = 8'($urandom_range(0, 255));
  endtask

  // Presents a row once the DUT is back in IDLE and counts edges from the
  // accept edge to the blur_final pulse (-1 if none within the bound).
  task automatic drive_row(input logic [31:0] x, input logic [31:0] y,
                           input logic [7:0] px [20], output int latency);
    repeat (2) @(negedge clk);
    anchor_x = x;
    anchor_y = y;
    for (int c = 0; c < 20; c++) blur_in[c] = px[c];
    anchor_moving = 1'b1;
    model_accept(x, px);
    latency = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (blur_final) begin
        latency = i - 1;
        break;
      end
    end
    $display("row x=%0d y=%0d latency=%0d", x, y, latency);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (blur_final !== 1'b0) begin
      failures++;
      $display("FAIL reset_final got=%b exp=0", blur_final);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (blur_out[k] !== 8'd0) begin
        failures++;
        $display("FAIL reset_out k=%0d got=%0d exp=0", k, blur_out[k]);
      end
    end
    n_rst = 1'b1;
    model_reset();
    $display("reset released");
  endtask

  task automatic test_uniform(input logic [31:0] y);
    logic [7:0] px [20];
    int lat;
    fill_const(px, 8'd200);
    drive_row(32'd0, y, px, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL uniform_latency got=%0d exp=16", lat);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (blur_out[k] !== 8'd200) begin
        failures++;
        $display("FAIL uniform k=%0d got=%0d exp=200", k, blur_out[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] px [20];
    int lat;
    for (int pass = 0; pass < 2; pass++) begin
      logic [7:0] v;
      v = (pass == 0) ? 8'd255 : 8'd0;
      fill_const(px, v);
      drive_row(32'd0, 32'(1 + pass), px, lat);
      checks++;
      if (lat !== 16) begin
        failures++;
        $display("FAIL saturation_latency v=%0d got=%0d exp=16", v, lat);
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (blur_out[k] !== v) begin
          failures++;
          $display("FAIL saturation k=%0d got=%0d exp=%0d", k, blur_out[k], v);
        end
      end
    end
  endtask

  task automatic test_impulse();
    logic [7:0] px [20];
    logic [7:0] exp_v;
    int lat;
    fill_const(px, 8'd0);
    drive_row(32'd0, 32'd3, px, lat);
    px[10] = 8'd255;
    drive_row(32'd1, 32'd3, px, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL impulse_latency got=%0d exp=16", lat);
    end
    for (int k = 0; k < 16; k++) begin
      exp_v = (k == 8) ? 8'd6 : ((k == 7 || k == 9) ? 8'd3 : 8'd0);
      checks++;
      if (blur_out[k] !== exp_v) begin
        failures++;
        $display("FAIL impulse k=%0d got=%0d exp=%0d", k, blur_out[k], exp_v);
      end
    end
  endtask

  task automatic test_border_sequence();
    logic [7:0] px [20];
    int lat;
    for (int x = 0; x < 3; x++) begin
      fill_rand(px);
      drive_row(32'(x), 32'd100, px, lat);
      checks++;
      if (lat !== 16) begin
        failures++;
        $display("FAIL border_latency x=%0d got=%0d exp=16", x, lat);
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (int'(blur_out[k]) !== model_pixel(k)) begin
          failures++;
          $display("FAIL border x=%0d k=%0d got=%0d exp=%0d", x, k, blur_out[k], model_pixel(k));
        end
      end
    end
  endtask

  task automatic test_no_retrigger();
    logic [7:0] snap [16];
    int pulses = 0;
    for (int k = 0; k < 16; k++) snap[k] = blur_out[k];
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (blur_final) pulses++;
    end
    $display("hold anchor 40 cycles pulses=%0d", pulses);
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL no_retrigger_pulses got=%0d exp=0", pulses);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (blur_out[k] !== snap[k]) begin
        failures++;
        $display("FAIL no_retrigger_hold k=%0d got=%0d exp=%0d", k, blur_out[k], snap[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] px [20];
    int lat;
    int edges;
    fill_rand(px);
    drive_row(32'd0, 32'd200, px, lat);
    // New row presented while still in DONE; accepted on the first IDLE edge.
    @(negedge clk);
    fill_rand(px);
    anchor_x = 32'd1;
    for (int c = 0; c < 20; c++) blur_in[c] = px[c];
    model_accept(32'd1, px);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (blur_final) begin
        edges = i;
        break;
      end
    end
    $display("back_to_back row x=1 edges=%0d", edges);
    checks++;
    if (edges !== 18) begin
      failures++;
      $display("FAIL back_to_back_edges got=%0d exp=18", edges);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (int'(blur_out[k]) !== model_pixel(k)) begin
        failures++;
        $display("FAIL back_to_back k=%0d got=%0d exp=%0d", k, blur_out[k], model_pixel(k));
      end
    end
  endtask

  task automatic test_random_rows();
    logic [7:0] px [20];
    int lat;
    int x = 0;
    for (int n = 0; n < 6; n++) begin
      x = ($urandom_range(0, 3) == 0) ? 0 : x + 1;
      fill_rand(px);
      drive_row(32'(x), 32'(300 + n), px, lat);
      checks++;
      if (lat !== 16) begin
        failures++;
        $display("FAIL random_latency n=%0d got=%0d exp=16", n, lat);
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (int'(blur_out[k]) !== model_pixel(k)) begin
          failures++;
          $display("FAIL random n=%0d k=%0d got=%0d exp=%0d", n, k, blur_out[k], model_pixel(k));
        end
      end
    end
    anchor_moving = 1'b0;
  endtask

  task automatic test_reset_mid_compute();
    logic [7:0] px [20];
    int pulses = 0;
    repeat (2) @(negedge clk);
    fill_rand(px);
    anchor_x = 32'd5;
    anchor_y = 32'd7;
    for (int c = 0; c < 20; c++) blur_in[c] = px[c];
    anchor_moving = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    checks++;
    if (blur_final !== 1'b0) begin
      failures++;
      $display("FAIL abort_final got=%b exp=0", blur_final);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (blur_out[k] !== 8'd0) begin
        failures++;
        $display("FAIL abort_out k=%0d got=%0d exp=0", k, blur_out[k]);
      end
    end
    anchor_moving = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (blur_final) pulses++;
    end
    $display("reset mid-compute pulses_after=%0d", pulses);
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL abort_pulse got=%0d exp=0", pulses);
    end
    test_uniform(32'd7);
  endtask

  initial begin
    for (int c = 0; c < 20; c++) blur_in[c] = 8'd0;
    test_reset();
    test_uniform(32'd0);
    test_saturation();
    test_impulse();
    test_border_sequence();
    test_no_retrigger();
    test_back_to_back();
    test_random_rows();
    test_reset_mid_compute();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
